// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart peripheral: software pushes through a small register
// window and a drain FSM polls UART STATUS.busy and writes each byte to TXDATA.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        uart_we_o,
  output logic [31:0] uart_addr_o,
  output logic [31:0] uart_data_o,
  input  logic [31:0] uart_data_i
);

  typedef enum logic [1:0] {POLL, WRITE, CHECK} state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_e        state_q;
  logic          drain_en_q, drain_en_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic          uart_we_q;
  logic [31:0]   uart_addr_q, uart_data_q;

  logic       sel_ctrl, sel_status, push_req, flush, push_ok, pop, full, empty;
  logic       uart_busy;
  logic [7:0] reg_addr;
  logic       unused_bits;

  assign reg_addr    = addr_i[7:0];
  assign unused_bits = ^{addr_i[31:8], data_i[31:8], uart_data_i[31:1]};
  assign uart_busy   = uart_data_i[0];

  assign sel_ctrl   = we_i && (reg_addr == 8'h00);
  assign sel_status = we_i && (reg_addr == 8'h04);
  assign push_req   = we_i && (reg_addr == 8'h08);
  assign flush      = sel_ctrl && data_i[1];

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Flush wins over both sides of the FIFO in the same cycle.
  assign push_ok = push_req && !full && !flush;
  assign pop     = (state_q == CHECK) && uart_busy && !flush && !empty;

  always_comb begin
    drain_en_d = drain_en_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (sel_ctrl)
      drain_en_d = data_i[0];
    if (sel_status && data_i[2])
      overflow_d = 1'b0;
    if (push_req && full && !flush)
      overflow_d = 1'b1;
    if (push_ok)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drain_en_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      drain_en_q <= drain_en_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= data_i[7:0];
  end

  // Outputs are loaded with the value belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= POLL;
      uart_we_q   <= 1'b0;
      uart_addr_q <= 32'h4;
      uart_data_q <= 32'h0;
    end else begin
      case (state_q)
        POLL: begin
          if (drain_en_q && !empty && !uart_busy && !flush) begin
            state_q     <= WRITE;
            uart_we_q   <= 1'b1;
            uart_addr_q <= 32'hC;
            uart_data_q <= {24'h0, mem_q[rd_ptr_q]};
          end
        end
        WRITE: begin
          state_q     <= flush ? POLL : CHECK;
          uart_we_q   <= 1'b0;
          uart_addr_q <= 32'h4;
          uart_data_q <= 32'h0;
        end
        CHECK: begin
          state_q     <= POLL;
          uart_we_q   <= 1'b0;
          uart_addr_q <= 32'h4;
          uart_data_q <= 32'h0;
        end
        default: begin
          state_q     <= POLL;
          uart_we_q   <= 1'b0;
          uart_addr_q <= 32'h4;
          uart_data_q <= 32'h0;
        end
      endcase
    end
  end

  assign uart_we_o   = uart_we_q;
  assign uart_addr_o = uart_addr_q;
  assign uart_data_o = uart_data_q;

  always_comb begin
    data_o = 32'h0;
    if (rst) begin
      case (reg_addr)
        8'h00: data_o[0] = drain_en_q;
        8'h04: begin
          data_o[0]      = full;
          data_o[1]      = empty;
          data_o[2]      = overflow_q;
          data_o[8+AW:8] = count_q;
        end
        default: data_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART (busy for 10 cycles
// per accepted byte, optionally ignoring writes) and an expected-byte queue.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h4;
  logic [31:0] data_i = 32'h0;
  logic [31:0] data_o;
  logic        uart_we_o;
  logic [31:0] uart_addr_o;
  logic [31:0] uart_data_o;
  logic [31:0] uart_data_i;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  bit         tx_en    = 1'b1;
  int         busy_cnt = 0;
  int         acc_cnt  = 0;
  int         att_cnt  = 0;
  logic       uart_busy;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .uart_we_o   (uart_we_o),
    .uart_addr_o (uart_addr_o),
    .uart_data_o (uart_data_o),
    .uart_data_i (uart_data_i)
  );

  always #5 clk = ~clk;

  assign uart_busy   = (busy_cnt != 0);
  assign uart_data_i = (uart_addr_o == 32'h4) ? {31'b0, uart_busy} : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // UART model and scoreboard on every TXDATA write.
  always @(posedge clk) begin
    if (rst && uart_we_o && uart_addr_o == 32'hC) begin
      check("wr_idle", {31'b0, uart_busy}, 32'h0);
      if (exp_q.size() == 0)
        check("tx_unexpected", uart_data_o, 32'hFFFF_FFFF);
      else if (tx_en) begin
        check("tx_byte", uart_data_o, {24'h0, exp_q.pop_front()});
        acc_cnt <= acc_cnt + 1;
      end else begin
        check("retry_byte", uart_data_o, {24'h0, exp_q[0]});
        att_cnt <= att_cnt + 1;
      end
    end
    if (rst && uart_we_o && uart_addr_o == 32'hC && tx_en && !uart_busy)
      busy_cnt <= 10;
    else if (busy_cnt != 0)
      busy_cnt <= busy_cnt - 1;
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i   = 1'b1;
    addr_i = {24'h0, a};
    data_i = d;
    @(posedge clk);
    #1;
    we_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_tx);
    bus_write(8'h08, {24'h0, b});
    if (expect_tx) exp_q.push_back(b);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr_i = {24'h0, a};
    #1;
    check(tag, data_o, exp);
  endtask

  // Ends on the negedge inside the WRITE cycle.
  task automatic wait_we();
    int n = 0;
    @(negedge clk);
    while (!uart_we_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_we", {31'b0, uart_we_o}, 32'h1);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_data_o", data_o, 32'h0);
    check("rst_uart_we", {31'b0, uart_we_o}, 32'h0);
    check("rst_uart_addr", uart_addr_o, 32'h4);
    check("rst_uart_data", uart_data_o, 32'h0);
    rst = 1'b1;
    read_chk("rst_status", 8'h04, 32'h2);
    read_chk("rst_ctrl", 8'h00, 32'h0);

    // Three back-to-back bytes drain in order
    bus_write(8'h00, 32'h1);
    push(8'h41, 1);
    push(8'h42, 1);
    push(8'h43, 1);
    repeat (60) @(posedge clk);
    read_chk("drain3_status", 8'h04, 32'h2);
    check("drain3_acc", acc_cnt, 32'd3);

    // Drain latency from an idle UART
    push(8'h44, 1);
    @(negedge clk);
    check("lat_poll_we", {31'b0, uart_we_o}, 32'h0);
    @(negedge clk);
    check("lat_write_we", {31'b0, uart_we_o}, 32'h1);
    check("lat_write_addr", uart_addr_o, 32'hC);
    check("lat_write_data", uart_data_o, 32'h44);
    @(negedge clk);
    addr_i = 32'h4;
    #1;
    check("lat_check_we", {31'b0, uart_we_o}, 32'h0);
    check("lat_check_addr", uart_addr_o, 32'h4);
    check("lat_check_cnt", data_o, 32'h100);
    @(negedge clk);
    #1;
    check("lat_popped", data_o, 32'h2);
    repeat (15) @(posedge clk);

    // Overflow, sticky bit, flush
    bus_write(8'h00, 32'h0);
    for (int i = 0; i <= DEPTH; i++) push(8'(i), 0);
    read_chk("ovf_status", 8'h04, 32'h1005);
    bus_write(8'h04, 32'h4);
    read_chk("ovf_clear", 8'h04, 32'h1001);
    read_chk("rd_txdata", 8'h08, 32'h0);
    read_chk("rd_other", 8'h0C, 32'h0);
    read_chk("rd_ctrl_off", 8'h00, 32'h0);
    push(8'hEE, 0);
    read_chk("ovf_again", 8'h04, 32'h1005);
    bus_write(8'h00, 32'h2);
    read_chk("flush_keeps_ovf", 8'h04, 32'h6);
    read_chk("flush_reads0", 8'h00, 32'h0);
    bus_write(8'h04, 32'h4);
    read_chk("ovf_clear2", 8'h04, 32'h2);

    // UART ignoring writes: head byte retried, then accepted once
    tx_en = 1'b0;
    bus_write(8'h00, 32'h1);
    read_chk("ctrl_on", 8'h00, 32'h1);
    push(8'h55, 1);
    repeat (20) @(posedge clk);
    check("retry_seen", {31'b0, (att_cnt >= 3)}, 32'h1);
    read_chk("retry_count", 8'h04, 32'h100);
    tx_en = 1'b1;
    repeat (20) @(posedge clk);
    read_chk("retry_done", 8'h04, 32'h2);
    check("retry_acc", acc_cnt, 32'd5);

    // Flush during CHECK: no pop underflow, next byte goes out next
    bus_write(8'h00, 32'h0);
    push(8'h60, 1);
    for (int i = 1; i < 5; i++) push(8'(8'h60 + i), 0);
    read_chk("flush5_count", 8'h04, 32'h500);
    bus_write(8'h00, 32'h1);
    wait_we();
    bus_write(8'h00, 32'h3);
    read_chk("flush_chk_status", 8'h04, 32'h2);
    repeat (15) @(posedge clk);
    push(8'h77, 1);
    repeat (20) @(posedge clk);
    read_chk("post_flush_status", 8'h04, 32'h2);
    check("post_flush_acc", acc_cnt, 32'd7);

    // Push and pop on the same edge at count 3
    bus_write(8'h00, 32'h0);
    push(8'h80, 1);
    push(8'h81, 1);
    push(8'h82, 1);
    read_chk("pp_count3", 8'h04, 32'h300);
    bus_write(8'h00, 32'h1);
    wait_we();
    push(8'h83, 1);
    read_chk("pp_still3", 8'h04, 32'h300);
    repeat (80) @(posedge clk);
    read_chk("pp_drained", 8'h04, 32'h2);

    // 2*DEPTH bytes through the FIFO so both pointers wrap
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) push(8'(8'hA0 + b * 8 + i), 1);
      repeat (130) @(posedge clk);
    end
    read_chk("wrap_status", 8'h04, 32'h2);
    check("wrap_exp_empty", exp_q.size(), 32'h0);
    check("total_acc", acc_cnt, 32'd43);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO that sits directly upstream of the `uart` peripheral and drains into it. The core pushes bytes through a small slave register window. A drain state machine masters the UART's register port: it polls STATUS.busy and writes each byte to TXDATA, so software no longer spins on the UART busy bit for every character.

## Interface
- `DEPTH`, 16: FIFO entries. Power of two, 2..256.
- `AW`, 4: log2(DEPTH).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `we_i`  in  1  slave write strobe from the bus.
- `addr_i`  in  32  slave address; only `[7:0]` is decoded.
- `data_i`  in  32  slave write data.
- `data_o`  out  32  slave read data, combinational.
- `uart_we_o`  out  1  write strobe to the UART `we_i`.
- `uart_addr_o`  out  32  address to the UART `addr_i`.
- `uart_data_o`  out  32  write data to the UART `data_i`.
- `uart_data_i`  in  32  UART `data_o`, combinational read of `uart_addr_o`.

## Operation
Slave registers:
- 0x00 CTRL (rw)
  - bit0 drain_en.
  - bit1 flush: write 1 to flush; self-clearing; reads 0.
- 0x04 STATUS (ro except bit2)
  - bit0 full, bit1 empty, bit2 overflow (sticky; write 1 to clear).
  - `[8+AW:8]` count, AW+1 bits.
- 0x08 TXDATA (wo): push `data_i[7:0]`.
- Reads of 0x08, or any other address, return 0. While `rst`=0, `data_o`=0.

FIFO:
- Circular buffer with AW-bit read and write pointers that wrap modulo DEPTH, and an AW+1-bit count.
- Push when full: byte dropped, overflow set, pointers unchanged.
- Push and pop in the same cycle: both take effect; count unchanged.
- Flush: pointers and count go to 0. Flush beats a simultaneous push and a simultaneous pop. Overflow is not cleared by flush.

Drain FSM, states POLL, WRITE, CHECK:
- POLL
  - `uart_addr_o`=0x04, `uart_we_o`=0.
  - If drain_en, FIFO not empty and `uart_data_i[0]`=0, go to WRITE. Otherwise stay.
- WRITE
  - `uart_addr_o`=0x0C, `uart_we_o`=1, `uart_data_o`={24'h0, head byte}.
  - Always go to CHECK.
- CHECK
  - `uart_addr_o`=0x04, `uart_we_o`=0.
  - If `uart_data_i[0]`=1, pop the head and go to POLL.
  - If 0, the UART rejected the write (tx disabled): go to POLL without popping, so the same byte is retried.
- FSM outputs are registered: the value for a state is driven during the cycles the FSM is in that state.
- Flush while in WRITE or CHECK: no pop; next state is POLL.
- Clearing drain_en mid-sequence completes the current WRITE/CHECK, then holds in POLL.

## Timing
- Reset values:
  - state POLL; pointers, count, CTRL and overflow 0.
  - `uart_we_o`=0, `uart_addr_o`=32'h4, `uart_data_o`=0, `data_o`=0.
- Push visible in STATUS.count on the cycle after the `we_i` edge.
- Drain latency, UART idle and drain_en=1:
  - push at edge N → POLL sees non-empty at N+1 → WRITE during N+1..N+2 → CHECK during N+2..N+3 → pop at edge N+3.
  - UART STATUS.busy rises at the edge ending WRITE and is seen in CHECK.
- Minimum spacing between successive UART TXDATA writes is 3 cycles. Steady state is bounded by the UART frame time.
- full = (count==DEPTH); empty = (count==0). Both are combinational from count.

## Test plan
- Reset, then read 0x04 → 32'h2 (empty); `uart_we_o`=0; `uart_addr_o`=0x4.
- drain_en=1; push 0x41, 0x42, 0x43 back-to-back; model the UART busy for 10 cycles per byte → exactly three TXDATA writes carrying 0x41, 0x42, 0x43 in order. Each write occurs only while busy=0. Count ends at 0.
- drain_en=0; push DEPTH+1 bytes → STATUS full=1, overflow=1, count=DEPTH. Write 0x4 to 0x04 → overflow=0, full still 1.
- UART model ignores writes (tx disabled) → FSM cycles WRITE/CHECK/POLL, repeatedly re-sending the head byte 0x55, with count unchanged. Enable the model → 0x55 is accepted once and popped.
- Push 5 bytes, then flush during CHECK → count 0, empty 1, no pop underflow. The next pushed byte 0x77 is the next TXDATA write.
- Push in the same cycle as a pop at count=3 → count stays 3. Write-pointer wrap verified by pushing 2×DEPTH bytes with draining active.
